// File: rtl/icache_pkg.sv
// Shared constants, line type and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int IF_DATA_WID   = 512;
    localparam int LINE_BYTES    = 64;
    localparam int NUM_LINES     = 16;
    localparam int WORDS_PER_LINE = LINE_BYTES / 4;
    localparam int OFFSET_W      = $clog2(LINE_BYTES);
    localparam int INDEX_W       = $clog2(NUM_LINES);
    localparam int TAG_W         = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_ADDR_W   = 32 - OFFSET_W;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

    typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle registered hits, whole-line fill on miss.
// state | meaning
// IDLE  | accepting fetches; hits answered next cycle, misses launch a line fill
// FILL  | waiting for mem_done; installs the line regardless of rdy or rollback
module icache
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    input  logic                   fetch_en,
    input  logic [31:0]            fetch_pc,
    output logic                   fetch_valid,
    output logic [31:0]            fetch_inst,
    output logic [31:0]            fetch_resp_pc,
    output logic                   mem_en,
    output logic [31:0]            mem_pc,
    input  logic [IF_DATA_WID-1:0] mem_data,
    input  logic                   mem_done
);

    icache_state_e          state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    line_t                  data_q [NUM_LINES];
    logic [LINE_ADDR_W-1:0] miss_line_q, miss_line_d;

    logic                   fetch_valid_d;
    logic [31:0]            fetch_inst_d;
    logic [31:0]            fetch_resp_pc_d;
    logic                   mem_en_d;

    logic [INDEX_W-1:0]     req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   accept;
    logic                   fill_we;
    logic [INDEX_W-1:0]     fill_idx;
    logic [TAG_W-1:0]       fill_tag;

    always_comb begin
        req_idx  = fetch_pc[OFFSET_W+INDEX_W-1:OFFSET_W];
        req_tag  = fetch_pc[31:OFFSET_W+INDEX_W];
        hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        accept   = rdy && fetch_en && !rollback;
        fill_idx = miss_line_q[INDEX_W-1:0];
        fill_tag = miss_line_q[LINE_ADDR_W-1:INDEX_W];
    end

    always_comb begin
        state_d         = state_q;
        fetch_valid_d   = 1'b0;
        fetch_inst_d    = fetch_inst;
        fetch_resp_pc_d = fetch_resp_pc;
        mem_en_d        = mem_en;
        miss_line_d     = miss_line_q;
        fill_we         = 1'b0;
        case (state_q)
            ICACHE_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        fetch_valid_d   = 1'b1;
                        fetch_inst_d    = data_q[req_idx][fetch_pc[OFFSET_W-1:2]];
                        fetch_resp_pc_d = fetch_pc;
                    end else begin
                        mem_en_d    = 1'b1;
                        miss_line_d = fetch_pc[31:OFFSET_W];
                        state_d     = ICACHE_FILL;
                    end
                end
            end
            ICACHE_FILL: begin
                // Fill completion ignores rdy and rollback so a done pulse is never lost.
                if (mem_done) begin
                    fill_we  = 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = ICACHE_IDLE;
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ICACHE_IDLE;
            valid_q       <= '0;
            miss_line_q   <= '0;
            fetch_valid   <= 1'b0;
            fetch_inst    <= '0;
            fetch_resp_pc <= '0;
            mem_en        <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_line_q   <= miss_line_d;
            fetch_valid   <= fetch_valid_d;
            fetch_inst    <= fetch_inst_d;
            fetch_resp_pc <= fetch_resp_pc_d;
            mem_en        <= mem_en_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data need no reset; valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    assign mem_pc = {miss_line_q, {OFFSET_W{1'b0}}};

endmodule
